wbc_bus_arbiter: RTL
====================

WBC_BUS_ARBITER -- requirements
Module: wbc_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of WISHBONE masters sharing the bus.
REQ-002 SHALL have parameter TIMEOUT, default 255, the number of waiting strobe cycles before a forced error; 0 disables the timeout.
REQ-003 SHALL have parameter TO_WIDTH, default 8, the width of the wait counter; TIMEOUT fits in TO_WIDTH bits.
REQ-004 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cyc_i, input, NUM_MASTERS, the per-master cyc request (bit n = master n).
REQ-007 SHALL have port stb_i, input, 1, the strobe of the currently granted master (already muxed).
REQ-008 SHALL have ports ack_i, err_i and rty_i, input, 1 each, the muxed slave responses.
REQ-009 SHALL have port gnt_o, output, NUM_MASTERS, registered grant, one-hot or all-zero.
REQ-010 SHALL have port to_err_o, output, 1, a registered one-cycle forced-error pulse, ORed by the interconnect into the granted master's err.
REQ-011 SHALL have port busy_o, output, 1, high while in the GRANT state.
REQ-012 SHALL have port timeout_cnt_o, output, 16, the saturating count of forced errors since reset.

Function
REQ-013 SHALL implement two states, IDLE and GRANT.
REQ-014 In IDLE, when any cyc_i bit is high at an edge, the block SHALL set gnt_o to the first requesting master scanning upward (with wrap) from last_gnt+1, store it as last_gnt, and enter GRANT.
REQ-015 Grant latency SHALL be exactly one clock from cyc_i sampled high in IDLE to gnt_o high.
REQ-016 In GRANT, gnt_o SHALL hold while cyc_i[last_gnt] is high; other requests SHALL be ignored (no preemption).
REQ-017 In GRANT, when cyc_i[last_gnt] is sampled low, the block SHALL clear gnt_o and return to IDLE at that edge, giving a minimum of one idle grant-free cycle between tenures.
REQ-018 If cyc_i[last_gnt] drops in the same cycle that a timeout fires, the drop SHALL win: no to_err_o, return to IDLE.
REQ-019 Wait counter, TO_WIDTH bits: in GRANT, it SHALL increment on each edge with stb_i=1, ack_i=err_i=rty_i=0 and to_err_o=0.
REQ-020 The wait counter SHALL clear on any response, on stb_i=0, in IDLE, and after a timeout.
REQ-021 Timeout: at an edge where TIMEOUT!=0, the counter equals TIMEOUT-1 and the waiting condition holds, the block SHALL set to_err_o=1 for exactly one cycle and clear the counter.
REQ-022 Consequently, to_err_o SHALL be high in the cycle after TIMEOUT consecutive waiting samples.
REQ-023 A response sampled on the same edge as the timeout condition SHALL win: no to_err_o, counter cleared.
REQ-024 While to_err_o=1, the counter SHALL not advance; counting SHALL resume on the next waiting edge.
REQ-025 timeout_cnt_o SHALL increment by 1 on each edge that sets to_err_o, and saturate at 0xFFFF.
REQ-026 With TIMEOUT=0, to_err_o SHALL stay 0 and timeout_cnt_o SHALL stay 0.
REQ-027 busy_o SHALL equal (state==GRANT), registered.
REQ-028 gnt_o SHALL never have more than one bit set.
REQ-029 Once gnt_o is nonzero, it SHALL change only via IDLE.

Reset
REQ-030 On rst_i=1 at an edge, the block SHALL set state=IDLE, gnt_o=0, to_err_o=0, busy_o=0, wait counter=0, timeout_cnt_o=0, and last_gnt=NUM_MASTERS-1 (so the first scan starts at master 0).
REQ-031 Reset asserted mid-tenure SHALL drop gnt_o on that edge regardless of cyc_i and SHALL suppress any pending to_err_o.
REQ-032 After reset deasserts, arbitration SHALL resume from IDLE on the next edge.

Verification
REQ-033 Bench SHALL check: after reset, cyc_i=3'b111 held -> gnt_o=001 one clock later; drop cyc0 -> gnt_o=000 for one cycle, then 010; drop cyc1 -> 000, then 100; drop cyc2 -> 000, then 001.
REQ-034 Bench SHALL check: master 1 granted, cyc_i goes 3'b011 then 3'b111 mid-tenure -> gnt_o stays 010 until cyc1 drops; the next grant is 100.
REQ-035 Bench SHALL check: TIMEOUT=4, stb_i held with no response -> to_err_o high for exactly one cycle after 4 waiting samples, then again after 4 more; timeout_cnt_o=1 then 2.
REQ-036 Bench SHALL check: TIMEOUT=4, ack_i sampled on the 4th waiting edge -> no to_err_o, timeout_cnt_o unchanged, and the counter restarts from 0.
REQ-037 Bench SHALL check: rst_i pulsed during GRANT with the counter at TIMEOUT-1 -> gnt_o=0, to_err_o=0 and timeout_cnt_o=0 next cycle; first post-reset grant goes to the lowest requesting index.
REQ-038 Bench SHALL check: timeout_cnt_o preloaded via 65535 timeouts -> the next timeout leaves it at 0xFFFF; TIMEOUT=0 with stb_i stuck high for 1000 cycles -> to_err_o never asserts.

Source files
------------

// File: rtl/wbc_bus_arbiter.sv
// wbc_bus_arbiter: round-robin WISHBONE bus arbiter with a strobe-wait timeout that forces a one-cycle error.
module wbc_bus_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int TIMEOUT     = 255,
   parameter int TO_WIDTH    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_MASTERS-1:0] cyc_i,
   input  logic                   stb_i,
   input  logic                   ack_i,
   input  logic                   err_i,
   input  logic                   rty_i,
   output logic [NUM_MASTERS-1:0] gnt_o,
   output logic                   to_err_o,
   output logic                   busy_o,
   output logic [15:0]            timeout_cnt_o
);
   localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IW-1:0] LAST_INIT = IW'(NUM_MASTERS - 1);
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t                 state, state_nx;
   logic [IW-1:0]          last_gnt, last_nx, pick, idx;
   logic [TO_WIDTH-1:0]    wait_cnt, wait_nx;
   logic [NUM_MASTERS-1:0] gnt_nx;
   logic [15:0]            tocnt_nx;
   logic                   found, owner_req, waiting, fire;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         last_gnt      <= LAST_INIT;
         wait_cnt      <= '0;
         gnt_o         <= '0;
         to_err_o      <= 1'b0;
         busy_o        <= 1'b0;
         timeout_cnt_o <= '0;
      end else begin
         state         <= state_nx;
         last_gnt      <= last_nx;
         wait_cnt      <= wait_nx;
         gnt_o         <= gnt_nx;
         to_err_o      <= fire;
         busy_o        <= state_nx == GRANT;
         timeout_cnt_o <= tocnt_nx;
      end
   end

   // Scan upward from the master after the last one granted, wrapping round.
   always_comb begin
      pick  = last_gnt;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = IW'((int'(last_gnt) + k) % NUM_MASTERS);
         if (!found && cyc_i[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // A dropped cyc or any response outranks a timeout landing on the same edge.
   always_comb begin
      owner_req = cyc_i[last_gnt];
      waiting   = stb_i & ~ack_i & ~err_i & ~rty_i & ~to_err_o;
      state_nx  = state == IDLE ? (found ? GRANT : IDLE) : (owner_req ? GRANT : IDLE);
      last_nx   = state == IDLE && found ? pick : last_gnt;
      fire      = TIMEOUT != 0 && state == GRANT && owner_req && waiting && wait_cnt == TO_LAST;
      wait_nx   = state == GRANT && owner_req && waiting && !fire ? wait_cnt + TO_WIDTH'(1) : '0;
   end

   always_comb begin
      gnt_nx   = state_nx == GRANT ? NUM_MASTERS'(1) << last_nx : '0;
      tocnt_nx = fire && timeout_cnt_o != 16'hFFFF ? timeout_cnt_o + 16'd1 : timeout_cnt_o;
   end
endmodule
